// File: rtl/riscv_dmem_arb.sv
// riscv_dmem_arb: two-requester data-memory arbiter (LSU = index 0, debug = index 1).
// A single transaction is in flight at a time. The grant is latched in IDLE and the
// owner's request is forwarded to memory until mem_ack_i or a TIMEOUT error ends it.
// Optional feature: define RV_DMEM_ARB_RR_EN for round-robin arbitration.
// Without it, LSU has fixed priority.
module riscv_dmem_arb #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [1:0]        req_i,
   input  logic [2*XLEN-1:0] adr_i,
   input  logic [1:0]        we_i,
   input  logic [2*XLEN-1:0] d_i,
   output logic [1:0]        ack_o,
   output logic [1:0]        err_o,
   output logic [XLEN-1:0]   q_o,
   output logic              mem_req_o,
   output logic [XLEN-1:0]   mem_adr_o,
   output logic              mem_we_o,
   output logic [XLEN-1:0]   mem_d_o,
   input  logic              mem_ack_i,
   input  logic [XLEN-1:0]   mem_q_i,
   output logic              busy_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e          state_q, state_d;
   logic            owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            winner;
   logic            timeout;
   logic            busy;
`ifdef RV_DMEM_ARB_RR_EN
   logic            last_q, last_d;
`endif

   assign busy    = (state_q == BUSY);
   assign timeout = (cnt_q == CW'(TIMEOUT));

   // Winner among the currently raised requests; only consulted when some bit is set.
   always_comb begin
`ifdef RV_DMEM_ARB_RR_EN
      // On a tie, the requester that was not granted last time wins.
      winner = (req_i == 2'b11) ? ~last_q : req_i[1];
`else
      // LSU wins whenever it is requesting.
      winner = ~req_i[0];
`endif
   end

   // Next-state logic: grant from IDLE, complete on ack, abort on timeout.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
`ifdef RV_DMEM_ARB_RR_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               state_d = BUSY;
               owner_d = winner;
               cnt_d   = '0;
`ifdef RV_DMEM_ARB_RR_EN
               last_d  = winner;
`endif
            end
         end
         BUSY: begin
            // Ack takes precedence over a timeout in the same cycle.
            if (mem_ack_i) begin
               state_d = IDLE;
            end else if (timeout) begin
               state_d = IDLE;
            end else begin
               // Counter stops at TIMEOUT because the FSM leaves BUSY there.
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         cnt_q   <= '0;
`ifdef RV_DMEM_ARB_RR_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
`ifdef RV_DMEM_ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end

   // Memory-side outputs: the owner's slice is forwarded while BUSY.
   always_comb begin
      mem_req_o = busy;
      mem_adr_o = owner_q ? adr_i[XLEN +: XLEN] : adr_i[0 +: XLEN];
      mem_d_o   = owner_q ? d_i[XLEN +: XLEN]   : d_i[0 +: XLEN];
      mem_we_o  = owner_q ? we_i[1]             : we_i[0];
      busy_o    = busy;
   end

   // Requester-side outputs: ack and err are steered one-hot to the owner.
   always_comb begin
      ack_o = 2'b00;
      err_o = 2'b00;
      q_o   = mem_q_i;
      if (busy && mem_ack_i) begin
         ack_o = owner_q ? 2'b10 : 2'b01;
      end else if (busy && timeout) begin
         err_o = owner_q ? 2'b10 : 2'b01;
      end
   end

endmodule
